stack_ram_port: RTL

- Dual-port stack data memory. It is the responder end of the pipeline's stack-memory interface.
- Port A serves the register-fetch stage's operand reads: mem_adr_a / mem_enable_a in, registered data out.
- Port B serves the execute stage's loads and stores, with byte enables for storeb/storeh.
- Same-cycle port B writes are forwarded into port A read data, so fetch never sees stale stack words.

---
 rtl/stack_ram_port.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stack_ram_port.sv
// Dual-port stack RAM: A = fetch reads, B = execute loads/stores with byte enables, both 1-cycle latency.
// No backpressure between ports; busy drops all requests. STACK_RAM_CLEAR_EN adds a post-reset zero-fill.
module stack_ram_port #(
  parameter int ram_depth_bits = 11,
  parameter int data_width     = 32,
  parameter int adr_width      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [adr_width-1:0]  mem_adr_a,
  input  logic                  mem_enable_a,
  output logic [data_width-1:0] mem_data_a,
  output logic                  mem_valid_a,
  input  logic [adr_width-1:0]  mem_adr_b,
  input  logic                  mem_enable_b,
  input  logic                  mem_we_b,
  input  logic [3:0]            mem_be_b,
  input  logic [data_width-1:0] mem_data_b_in,
  output logic [data_width-1:0] mem_data_b_out,
  output logic                  busy
);

  localparam int depth = 1 << ram_depth_bits;
  localparam int lane  = data_width / 4;

  logic [data_width-1:0] ram [depth];

  logic [ram_depth_bits-1:0] idx_a;
  logic [ram_depth_bits-1:0] idx_b;
  logic                      accept;
  logic                      wr_b;
  logic [data_width-1:0]     fwd_a;

  // Byte offset and bits above the RAM depth are don't-care: addresses alias modulo depth.
  assign idx_a  = mem_adr_a[ram_depth_bits+1:2];
  assign idx_b  = mem_adr_b[ram_depth_bits+1:2];
  assign accept = !busy;
  assign wr_b   = accept && mem_enable_b && mem_we_b;

  wire unused_adr = ^{mem_adr_a[adr_width-1:ram_depth_bits+2], mem_adr_a[1:0],
                      mem_adr_b[adr_width-1:ram_depth_bits+2], mem_adr_b[1:0]};

  // Port A sees a same-cycle port B store byte-by-byte, so fetch never returns a stale word.
  always_comb begin
    fwd_a = ram[idx_a];
    for (int i = 0; i < 4; i++) begin
      if (wr_b && (idx_a == idx_b) && mem_be_b[i]) begin
        fwd_a[i*lane +: lane] = mem_data_b_in[i*lane +: lane];
      end
    end
  end

`ifdef STACK_RAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;

  clr_state_t                state;
  clr_state_t                state_nxt;
  logic [ram_depth_bits-1:0] clr_cnt;
  logic [ram_depth_bits-1:0] clr_cnt_nxt;
  logic                      clr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    busy        = 1'b0;
    case (state)
      CLEAR: begin
        busy        = 1'b1;
        clr_we      = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == '1) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      ram[clr_cnt] <= '0;
    end
    if (wr_b) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_b[i]) begin
          ram[idx_b][i*lane +: lane] <= mem_data_b_in[i*lane +: lane];
        end
      end
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (wr_b) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_b[i]) begin
          ram[idx_b][i*lane +: lane] <= mem_data_b_in[i*lane +: lane];
        end
      end
    end
  end
`endif

  // Port B is read-first: a store returns the word as it was before the store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data_a     <= '0;
      mem_valid_a    <= 1'b0;
      mem_data_b_out <= '0;
    end else begin
      if (accept && mem_enable_a) begin
        mem_data_a  <= fwd_a;
        mem_valid_a <= 1'b1;
      end else begin
        mem_valid_a <= 1'b0;
      end
      if (accept && mem_enable_b) begin
        mem_data_b_out <= ram[idx_b];
      end
    end
  end

endmodule
